// File: rtl/spi_pwm_config_ctrl.sv
// Write-only SPI mode-0 target holding the PWM peripheral configuration registers.
// SPI pins are oversampled in the clk domain; 16-bit frames are committed on nCS rise.
module spi_pwm_config_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic sclk_d, ncs_d;
    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic        frame_start, shift_bit, frame_done;
    logic        commit_wr, commit_err;

    // Synchronisers reset to the idle bus levels so reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An sclk rise coinciding with the nCS rise is dropped; the frame ends first.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        shift_bit   = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end else if (sclk_rise) begin
                    shift_bit = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign commit_wr  = frame_done && (bit_cnt == 5'd16) && shreg[15]
                        && (shreg[14:8] <= MAX_ADDR);
    assign commit_err = frame_done && (bit_cnt != 5'd16);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg           <= '0;
            bit_cnt         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
            wr_addr         <= '0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= commit_wr;
            frame_err <= commit_err;
            if (frame_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_bit) begin
                shreg <= {shreg[14:0], copi_s};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (commit_wr) begin
                wr_addr <= shreg[14:8];
                case (shreg[14:8])
                    7'h00:   en_reg_out_7_0  <= shreg[7:0];
                    7'h01:   en_reg_out_15_8 <= shreg[7:0];
                    7'h02:   en_reg_pwm_7_0  <= shreg[7:0];
                    7'h03:   en_reg_pwm_15_8 <= shreg[7:0];
                    7'h04:   pwm_duty_cycle  <= shreg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_pwm_config_ctrl.sv
// Randomised scoreboard bench for spi_pwm_config_ctrl: a frame-level register model
// predicts commits and length errors; a monitor pops them as the DUT pulses its outputs.
`timescale 1ns/1ps
module tb_spi_pwm_config_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe, frame_err;
    logic [6:0] wr_addr;

    typedef struct {
        logic       is_err;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_regs[5];
    int         vectors     = 0;
    int         miscompares = 0;

    spi_pwm_config_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe),
        .wr_addr        (wr_addr),
        .frame_err      (frame_err)
    );

    always #10 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int idx);
        case (idx)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    // Frame-level model: only a 16-bit write to an address 0..4 changes anything.
    task automatic modelFrame(input logic [31:0] word, input int nbits);
        exp_t e;
        logic [15:0] f;
        f = word[15:0];
        if (nbits != 16) begin
            e.is_err = 1'b1; e.addr = 7'h00; e.data = 8'h00;
            exp_q.push_back(e);
        end else if (f[15] && (int'(f[14:8]) <= 4)) begin
            model_regs[int'(f[14:8])] = f[7:0];
            e.is_err = 1'b0; e.addr = f[14:8]; e.data = f[7:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic driveBits(input logic [31:0] word, input int nbits, input int half);
        ncs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            copi = word[nbits-1-i];
            #(half);
            sclk = 1'b1;
            #(half);
            sclk = 1'b0;
        end
        #(half);
    endtask

    task automatic checkOutput(input string tag);
        repeat (8) @(posedge clk);
        #1;
        cmp({tag, " pending"}, exp_q.size(), 0);
        for (int r = 0; r < 5; r++) begin
            cmp($sformatf("%s reg%0d", tag, r), dut_reg(r), model_regs[r]);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int nbits, input int half, input string tag);
        #($urandom_range(0, 19));
        modelFrame(word, nbits);
        driveBits(word, nbits, half);
        ncs  = 1'b1;
        copi = 1'b0;
        #($urandom_range(60, 100));
        checkOutput(tag);
    endtask

    // Monitor: every strobe or error pulse must match the oldest predicted event.
    always @(negedge clk) begin
        if (!rst && (wr_strobe || frame_err)) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected pulse", {30'd0, wr_strobe, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                cmp("pulse kind", {30'd0, wr_strobe, frame_err}, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    cmp("wr_addr", wr_addr, e.addr);
                    cmp("committed data", dut_reg(int'(e.addr)), e.data);
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        int nb, sel;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int r = 0; r < 5; r++) model_regs[r] = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp("reset wr_strobe", wr_strobe, 0);
        cmp("reset frame_err", frame_err, 0);
        cmp("reset wr_addr", wr_addr, 0);
        checkOutput("reset");

        applyStimulus(32'h80FF, 16, 100, "wr 80FF");
        applyStimulus(32'h8480, 16, 100, "wr 8480");
        applyStimulus(32'h00AA, 16, 100, "read bit");
        applyStimulus(32'h8555, 16, 100, "addr 5");
        applyStimulus(32'h8155 >> 1, 15, 100, "15 bits");
        applyStimulus({15'd0, 16'h8155, 1'b1}, 17, 100, "17 bits");

        $display("[TB] reset mid-frame");
        driveBits(32'h833C >> 7, 9, 100);
        @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        ncs = 1'b1; copi = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 5; r++) model_regs[r] = 8'h00;
        checkOutput("after reset");
        applyStimulus(32'h833C, 16, 100, "wr 833C");

        for (int i = 0; i < 8; i++) begin
            #100 sclk = 1'b1;
            #100 sclk = 1'b0;
        end
        #100;
        checkOutput("stray sclk");
        applyStimulus(32'h820F, 16, 100, "wr 820F");

        $display("[TB] random frames");
        for (int n = 0; n < 400; n++) begin
            w   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      nb = 15;
            else if (sel == 1) nb = 17;
            else if (sel == 2) nb = $urandom_range(1, 20);
            else begin
                nb = 16;
                w[15]   = ($urandom_range(0, 4) != 0);
                w[14:8] = 7'($urandom_range(0, 7));
            end
            applyStimulus(w, nb, $urandom_range(41, 90), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
